// File: rtl/tag_prefix_decoder.sv
// Serial receiver for 2-bit tag-prefix frames ({1, tag, payload}, MSB first).
// Strips the header and hands payload/tag out through a one-entry valid/ready register.
module tag_prefix_decoder #(
  parameter int PAYLOAD_W  = 2,
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  output logic [PAYLOAD_W-1:0]  payload_out,
  output logic                  tag_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int CNT_W = (PAYLOAD_W > 1) ? $clog2(PAYLOAD_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAYLOAD_W - 1);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    TAG  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t               state;
  logic                 tag_reg;
  logic [CNT_W-1:0]     cnt;
  logic [PAYLOAD_W-1:0] shift;
  logic [PAYLOAD_W-1:0] shift_nxt;
  logic                 done;
  logic                 can_load;
  logic                 drop_sat;

  generate
    if (PAYLOAD_W == 1) begin : g_one
      assign shift_nxt = bit_in;
    end else begin : g_multi
      assign shift_nxt = {shift[PAYLOAD_W-2:0], bit_in};
    end
  endgenerate

  assign done     = bit_valid && (state == DATA) && (cnt == CNT_LAST);
  assign can_load = !out_valid || out_ready;
  assign drop_sat = &drop_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      tag_reg     <= 1'b0;
      cnt         <= '0;
      shift       <= '0;
      payload_out <= '0;
      tag_out     <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      drop_count  <= '0;
    end else begin
      // A completing frame below may re-set out_valid in the same cycle.
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      if (bit_valid) begin
        unique case (state)
          HUNT: begin
            if (bit_in) begin
              state <= TAG;
              busy  <= 1'b1;
            end
          end
          TAG: begin
            tag_reg <= bit_in;
            cnt     <= '0;
            state   <= DATA;
          end
          DATA: begin
            shift <= shift_nxt;
            cnt   <= cnt + 1'b1;
            if (done) begin
              state <= HUNT;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= HUNT;
            busy  <= 1'b0;
          end
        endcase
      end

      if (done) begin
        if (can_load) begin
          payload_out <= shift_nxt;
          tag_out     <= tag_reg;
          out_valid   <= 1'b1;
        end else if (!drop_sat) begin
          drop_count <= drop_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tag_prefix_decoder.sv
// Randomized bench for tag_prefix_decoder against a queue-based frame parser model.
// A second PAYLOAD_W=4 instance covers drop counter saturation.
module tb_tag_prefix_decoder;

  localparam int W  = 2;
  localparam int W4 = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          bit_in;
  logic          bit_valid;
  logic          out_ready;
  logic [W-1:0]  payload_out;
  logic          tag_out;
  logic          out_valid;
  logic          busy;
  logic [DW-1:0] drop_count;

  logic          reset4;
  logic          bit_in4;
  logic          bit_valid4;
  logic          out_ready4;
  logic [W4-1:0] payload_out4;
  logic          tag_out4;
  logic          out_valid4;
  logic          busy4;
  logic [DW-1:0] drop_count4;

  always #5 clk = ~clk;

  tag_prefix_decoder #(.PAYLOAD_W(W), .DROP_CNT_W(DW)) u_dut (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .payload_out(payload_out), .tag_out(tag_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .drop_count(drop_count)
  );

  tag_prefix_decoder #(.PAYLOAD_W(W4), .DROP_CNT_W(DW)) u_dut4 (
    .clk(clk), .reset(reset4), .bit_in(bit_in4), .bit_valid(bit_valid4),
    .payload_out(payload_out4), .tag_out(tag_out4), .out_valid(out_valid4),
    .out_ready(out_ready4), .busy(busy4), .drop_count(drop_count4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Model: the queue holds the bits of the frame in progress.
  bit m_q[$];
  bit m_valid;
  int m_payload;
  bit m_tag;
  int m_drop;

  task automatic model(input bit v, input bit b, input bit r, input bit rs);
    bit fire;
    bit complete;
    int p;
    if (rs) begin
      m_q.delete();
      m_valid = 0; m_payload = 0; m_tag = 0; m_drop = 0;
      return;
    end
    fire = m_valid && r;
    complete = 0;
    p = 0;
    if (v && !(m_q.size() == 0 && b == 0)) begin
      m_q.push_back(b);
      if (m_q.size() == W + 2) begin
        complete = 1;
        for (int i = 0; i < W; i++) p = p * 2 + int'(m_q[i+2]);
      end
    end
    if (complete) begin
      if (!m_valid || r) begin
        m_payload = p; m_tag = m_q[1]; m_valid = 1;
      end else if (m_drop < (1 << DW) - 1) begin
        m_drop++;
      end
      m_q.delete();
    end else if (fire) begin
      m_valid = 0;
    end
  endtask

  task automatic step(input bit v, input bit b, input bit r, input bit rs);
    bit_valid = v; bit_in = b; out_ready = r; reset = rs;
    @(posedge clk);
    model(v, b, r, rs);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_q.size() != 0));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
    chk("tag_out", 32'(tag_out), 32'(m_tag));
    chk("payload_out", 32'(payload_out), 32'(m_payload));
  endtask

  task automatic send(input logic [31:0] bits, input int n, input bit r,
                      input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      step(1, bits[i], r, 0);
      if (i != 0)
        for (int g = 0; g < gap; g++) step(0, 0, r, 0);
    end
  endtask

  task automatic step4(input bit v, input bit b, input bit r, input bit rs);
    bit_valid4 = v; bit_in4 = b; out_ready4 = r; reset4 = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] f;
    reset = 1; bit_valid = 0; bit_in = 0; out_ready = 0;
    reset4 = 1; bit_valid4 = 0; bit_in4 = 0; out_ready4 = 0;

    step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_busy", 32'(busy), 0);

    // Basic frame, tag 0 payload 01.
    send(32'b1001, 4, 1, 0);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_tag", 32'(tag_out), 0);
    chk("t1_payload", 32'(payload_out), 32'b01);
    step(0, 0, 1, 0);

    // Leading zeros ignored.
    send(32'b000, 3, 1, 0);
    send(32'b1110, 4, 1, 0);
    chk("t2_tag", 32'(tag_out), 1);
    chk("t2_payload", 32'(payload_out), 32'b10);

    // Gaps between bits.
    send(32'b1011, 4, 1, 3);
    chk("t3_tag", 32'(tag_out), 0);
    chk("t3_payload", 32'(payload_out), 32'b11);
    step(0, 0, 1, 0);

    // Backpressure: hold first, drop second, then consume+load together.
    send(32'b1001, 4, 0, 0);
    send(32'b1110, 4, 0, 0);
    chk("t4_drop", 32'(drop_count), 1);
    chk("t4_payload", 32'(payload_out), 32'b01);
    send(32'b110, 3, 0, 0);
    step(1, 1, 1, 0);
    chk("t4_valid", 32'(out_valid), 1);
    chk("t4_tag3", 32'(tag_out), 1);
    chk("t4_payload3", 32'(payload_out), 32'b01);
    step(0, 0, 1, 0);

    // Reset mid-payload.
    send(32'b111, 3, 1, 0);
    step(0, 0, 1, 1);
    send(32'b1010, 4, 1, 0);
    chk("t5_tag", 32'(tag_out), 0);
    chk("t5_payload", 32'(payload_out), 32'b10);
    chk("t5_drop", 32'(drop_count), 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, $urandom % 2, ($urandom % 3) != 0,
           ($urandom % 500) == 0);
    end

    // Saturation on the PAYLOAD_W=4 instance.
    step4(0, 0, 0, 1);
    for (int k = 1; k <= 300; k++) begin
      f = (k == 1) ? 32'b111010 : (32'b100000 | ($urandom % 32));
      for (int i = 5; i >= 0; i--) step4(1, f[i], 0, 0);
      if (k == 1) chk("sat_first_valid", 32'(out_valid4), 1);
      if (k == 255) chk("sat_254", 32'(drop_count4), 254);
      if (k == 256) chk("sat_255", 32'(drop_count4), 255);
    end
    chk("sat_300", 32'(drop_count4), 255);
    chk("sat_payload", 32'(payload_out4), 32'b1010);
    chk("sat_tag", 32'(tag_out4), 1);
    chk("sat_valid", 32'(out_valid4), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tag_prefix_decoder.md
Name: tag_prefix_decoder

Overview:
- Receive side of the 2-bit tag-prefix framing: frames are {2'b10, payload} (tag 0) or {2'b11, payload} (tag 1), sent serially MSB first.
- Hunts for the leading '1' of a header, captures the tag bit and then PAYLOAD_W payload bits.
- Presents the stripped payload and tag through a one-entry valid/ready output register, and counts frames dropped under backpressure.

Parameters:
- PAYLOAD_W, 2, payload bits per frame (legal range 1..16); a default frame is 4 bits total.
- DROP_CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data bit, MSB first.
- bit_valid  input  1  bit_in is meaningful this cycle. Bits are always accepted; there is no input backpressure.
- payload_out  output  PAYLOAD_W  stripped payload; first-received bit is the MSB.
- tag_out  output  1  0 = header 10, 1 = header 11.
- out_valid  output  1  payload_out/tag_out hold an unconsumed frame.
- out_ready  input  1  consumer accepts the frame when out_valid && out_ready.
- busy  output  1  high whenever state != HUNT.
- drop_count  output  DROP_CNT_W  number of completed frames discarded; saturating.

Behaviour:
- Reset, applied at any cycle including mid-frame:
  - state = HUNT; the partial frame is discarded.
  - payload_out = 0, tag_out = 0, out_valid = 0, busy = 0, drop_count = 0.
  - Shift register and bit counter cleared.
- FSM advances only on cycles with bit_valid = 1. With bit_valid = 0 it holds state, counter and shift register.
  - HUNT: bit_in = 0 stays in HUNT; leading zeros are idle fill and are ignored. bit_in = 1 goes to TAG.
  - TAG: tag_reg <= bit_in; cnt <= 0; go to DATA.
  - DATA: shift <= {shift[PAYLOAD_W-2:0], bit_in}; cnt <= cnt + 1. When cnt == PAYLOAD_W-1 the frame is complete and the FSM returns to HUNT. For PAYLOAD_W = 1, the shift is a direct load.
- Frames are back-to-back capable: the next header's leading '1' may arrive in the cycle immediately after the last payload bit.
- Completion cycle (last payload bit accepted):
  - If out_valid = 0, or out_valid = 1 and out_ready = 1 in the same cycle:
    - payload_out <= assembled payload (including this bit); tag_out <= tag_reg; out_valid <= 1.
    - Latency: output valid on the edge after the last payload bit. The simultaneous consume and load yields out_valid staying 1 with the new data.
  - Otherwise (buffer full, not being consumed): frame dropped; output registers unchanged; drop_count <= drop_count + 1 unless all-ones (saturates, no wrap).
- Outside a completion cycle, out_valid && out_ready clears out_valid next cycle. payload_out/tag_out retain their last values.
- payload_out/tag_out are stable while out_valid = 1 and out_ready = 0.
- busy is a registered decode of the state: high in TAG and DATA.
- No header validation beyond the leading '1'. Headers 00/01 cannot occur, since a zero in HUNT is consumed as idle fill.

Test Plan (PAYLOAD_W = 2 unless noted):
- Reset, then bits 1,0,0,1 on consecutive valid cycles with out_ready = 1 -> one cycle after the 4th bit: out_valid = 1, tag_out = 0, payload_out = 2'b01, drop_count = 0.
- Bits 0,0,0,1,1,1,0 -> leading zeros ignored; tag_out = 1, payload_out = 2'b10; busy high from the cycle after the first '1' until the frame completes.
- Frame 1,0,1,1 with bit_valid deasserted for 3 cycles between every bit -> same result as contiguous: tag 0, payload 2'b11; state held through the gaps.
- out_ready = 0; send frames 1,0,0,1 then 1,1,1,0 -> first frame held (tag 0, payload 01); second dropped, drop_count = 1. Then assert out_ready with a third frame completing in the same cycle as the consume -> third frame loaded, out_valid stays 1.
- Assert reset after 1,1,1 (mid-payload), then send 1,0,1,0 -> no output from the partial frame; tag 0, payload 2'b10; drop_count = 0.
- out_ready = 0 for 300 frames (PAYLOAD_W = 4, DROP_CNT_W = 8) -> drop_count saturates at 255; payload_out still equals the first frame.
